// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants and types for the ALU issue sequencer.
//   - MIPS32 opcode / funct field values understood by the decoder
//   - 3-bit ALU control encodings driven onto alu_control
//   - sequencer FSM state enum and operand-select enums
// Optional feature macro used by the users of this package: ALU_SEQ_OVF_EN.
package alu_seq_pkg;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  // R-type funct field values (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;

  // ALU control encodings; 3'b111 is never issued
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Operand A source
  typedef enum logic {
    A_SEL_RS = 1'b0,
    A_SEL_RT = 1'b1
  } a_sel_e;

  // Operand B source
  typedef enum logic [2:0] {
    B_SEL_RT    = 3'd0,  // rt_data
    B_SEL_SHAMT = 3'd1,  // zero-extended instr[10:6]
    B_SEL_RS5   = 3'd2,  // zero-extended rs_data[4:0]
    B_SEL_SEXT  = 3'd3,  // sign-extended imm16
    B_SEL_ZEXT  = 3'd4   // zero-extended imm16
  } b_sel_e;

  // Which signed-overflow rule applies in EXEC
  typedef enum logic [1:0] {
    OVF_NONE = 2'd0,
    OVF_ADD  = 2'd1,
    OVF_SUB  = 2'd2
  } ovf_kind_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: purely combinational MIPS32 decoder for the ALU sequencer.
// Ports:
//   instr       in   32  instruction word
//   alu_control out   3  ALU operation code
//   a_sel       out      operand A source
//   b_sel       out      operand B source
//   dest        out   5  destination register (rd for R-type, rt for I-type)
//   illegal     out   1  instruction not supported
//   ovf_kind    out      overflow rule (only with ALU_SEQ_OVF_EN)
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  alu_control,
  output a_sel_e      a_sel,
  output b_sel_e      b_sel,
  output logic [4:0]  dest,
  output logic        illegal
`ifdef ALU_SEQ_OVF_EN
  ,
  output ovf_kind_e   ovf_kind
`endif
);

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;
  logic       unused_fields_s;

  assign opcode_s = instr[31:26];
  assign funct_s  = instr[5:0];
  assign rt_s     = instr[20:16];
  assign rd_s     = instr[15:11];
  // rs index and shamt are consumed by the top's operand mux, not here
  assign unused_fields_s = ^{instr[25:21], instr[10:6]};

  // Field decode into ALU op, operand selects, destination and legality
  always_comb begin
    alu_control = ALU_ADD;
    a_sel       = A_SEL_RS;
    b_sel       = B_SEL_RT;
    dest        = 5'd0;
    illegal     = 1'b0;
`ifdef ALU_SEQ_OVF_EN
    ovf_kind    = OVF_NONE;
`endif
    case (opcode_s)
      OP_RTYPE: begin
        dest = rd_s;
        case (funct_s)
          FN_ADD: begin
            alu_control = ALU_ADD;
`ifdef ALU_SEQ_OVF_EN
            ovf_kind    = OVF_ADD;
`endif
          end
          FN_SUB: begin
            alu_control = ALU_SUB;
`ifdef ALU_SEQ_OVF_EN
            ovf_kind    = OVF_SUB;
`endif
          end
          FN_AND: alu_control = ALU_AND;
          FN_OR:  alu_control = ALU_OR;
          FN_XOR: alu_control = ALU_XOR;
          // Shifts shift rt; amount from shamt or rs_data[4:0].
          // instr==0 (nop) lands here as sll r0 and retires silently.
          FN_SLL: begin
            alu_control = ALU_SHL;
            a_sel       = A_SEL_RT;
            b_sel       = B_SEL_SHAMT;
          end
          FN_SRL: begin
            alu_control = ALU_SHR;
            a_sel       = A_SEL_RT;
            b_sel       = B_SEL_SHAMT;
          end
          FN_SLLV: begin
            alu_control = ALU_SHL;
            a_sel       = A_SEL_RT;
            b_sel       = B_SEL_RS5;
          end
          FN_SRLV: begin
            alu_control = ALU_SHR;
            a_sel       = A_SEL_RT;
            b_sel       = B_SEL_RS5;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dest        = rt_s;
        alu_control = ALU_ADD;
        b_sel       = B_SEL_SEXT;
`ifdef ALU_SEQ_OVF_EN
        ovf_kind    = OVF_ADD;
`endif
      end
      OP_ANDI: begin
        dest        = rt_s;
        alu_control = ALU_AND;
        b_sel       = B_SEL_ZEXT;
      end
      OP_ORI: begin
        dest        = rt_s;
        alu_control = ALU_OR;
        b_sel       = B_SEL_ZEXT;
      end
      OP_XORI: begin
        dest        = rt_s;
        alu_control = ALU_XOR;
        b_sel       = B_SEL_ZEXT;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multicycle issue controller driving a combinational ALU.
// Accepts one instruction per instr handshake, registers decoded operands,
// captures the ALU result one cycle later and offers it on the wb handshake.
// Optional feature macro: ALU_SEQ_OVF_EN (signed overflow trap on add/sub/addi,
// adds the ovf output).
// Ports:
//   clk, rst_n               clock, async active-low reset
//   instr_valid/instr_ready  instruction handshake
//   instr, rs_data, rt_data  instruction word and register operands
//   alu_a, alu_b, alu_control  registered ALU inputs
//   alu_result               combinational ALU output
//   wb_valid/wb_ready        writeback handshake, wb_addr/wb_data payload
//   illegal                  one-cycle pulse on an unsupported instruction
//   retired                  completed-instruction counter (wraps)
//   ovf                      one-cycle overflow pulse (ALU_SEQ_OVF_EN only)
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [2:0]        alu_control,
  input  logic [31:0]       alu_result,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_addr,
  output logic [31:0]       wb_data,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic              ovf
`endif
);

  state_e           state_r, state_nx;
  logic             instr_ready_r, instr_ready_nx;
  logic [31:0]      alu_a_r, alu_a_nx;
  logic [31:0]      alu_b_r, alu_b_nx;
  logic [2:0]       alu_control_r, alu_control_nx;
  logic             wb_valid_r, wb_valid_nx;
  logic [4:0]       wb_addr_r, wb_addr_nx;
  logic [31:0]      wb_data_r, wb_data_nx;
  logic             illegal_r, illegal_nx;
  logic [CNT_W-1:0] retired_r, retired_nx;

  logic [2:0]       dec_alu_control_s;
  a_sel_e           dec_a_sel_s;
  b_sel_e           dec_b_sel_s;
  logic [4:0]       dec_dest_s;
  logic             dec_illegal_s;
  logic [31:0]      op_a_s;
  logic [31:0]      op_b_s;

`ifdef ALU_SEQ_OVF_EN
  ovf_kind_e        dec_ovf_kind_s;
  ovf_kind_e        ovf_kind_r, ovf_kind_nx;
  logic             ovf_r, ovf_nx;
  logic             ovf_hit_s;
`endif

  alu_seq_decode u_decode (
    .instr       (instr),
    .alu_control (dec_alu_control_s),
    .a_sel       (dec_a_sel_s),
    .b_sel       (dec_b_sel_s),
    .dest        (dec_dest_s),
    .illegal     (dec_illegal_s)
`ifdef ALU_SEQ_OVF_EN
    ,
    .ovf_kind    (dec_ovf_kind_s)
`endif
  );

  // Operand selection from the decoder's select flags
  always_comb begin
    op_a_s = (dec_a_sel_s == A_SEL_RT) ? rt_data : rs_data;
    case (dec_b_sel_s)
      B_SEL_RT:    op_b_s = rt_data;
      B_SEL_SHAMT: op_b_s = {27'd0, instr[10:6]};
      B_SEL_RS5:   op_b_s = {27'd0, rs_data[4:0]};
      B_SEL_SEXT:  op_b_s = sign_ext16(instr[15:0]);
      B_SEL_ZEXT:  op_b_s = {16'd0, instr[15:0]};
      default:     op_b_s = rt_data;
    endcase
  end

`ifdef ALU_SEQ_OVF_EN
  // Signed overflow of the in-flight add/sub, judged on the live ALU result
  always_comb begin
    case (ovf_kind_r)
      OVF_ADD: ovf_hit_s = (alu_a_r[31] == alu_b_r[31]) && (alu_result[31] != alu_a_r[31]);
      OVF_SUB: ovf_hit_s = (alu_a_r[31] != alu_b_r[31]) && (alu_result[31] != alu_a_r[31]);
      default: ovf_hit_s = 1'b0;
    endcase
  end
`endif

  // Next-state and next-output logic; registers hold unless a state acts
  always_comb begin
    state_nx       = state_r;
    alu_a_nx       = alu_a_r;
    alu_b_nx       = alu_b_r;
    alu_control_nx = alu_control_r;
    wb_valid_nx    = wb_valid_r;
    wb_addr_nx     = wb_addr_r;
    wb_data_nx     = wb_data_r;
    illegal_nx     = 1'b0;
    retired_nx     = retired_r;
`ifdef ALU_SEQ_OVF_EN
    ovf_kind_nx    = ovf_kind_r;
    ovf_nx         = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (instr_valid && dec_illegal_s) begin
          illegal_nx = 1'b1;
        end else if (instr_valid) begin
          alu_a_nx       = op_a_s;
          alu_b_nx       = op_b_s;
          alu_control_nx = dec_alu_control_s;
          wb_addr_nx     = dec_dest_s;
`ifdef ALU_SEQ_OVF_EN
          ovf_kind_nx    = dec_ovf_kind_s;
`endif
          state_nx       = ST_EXEC;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_EXEC: begin
        wb_data_nx = alu_result;
`ifdef ALU_SEQ_OVF_EN
        if (ovf_hit_s) begin
          ovf_nx   = 1'b1;
          state_nx = ST_IDLE;
        end else
`endif
        if (wb_addr_r == 5'd0) begin
          // r0 destination: retire without a writeback
          retired_nx = retired_r + CNT_W'(1);
          state_nx   = ST_IDLE;
        end else begin
          wb_valid_nx = 1'b1;
          state_nx    = ST_WB;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          wb_valid_nx = 1'b0;
          retired_nx  = retired_r + CNT_W'(1);
          state_nx    = ST_IDLE;
        end else begin
          state_nx = ST_WB;
        end
      end
      default: begin
        wb_valid_nx = 1'b0;
        state_nx    = ST_IDLE;
      end
    endcase
    // Registered ready: high exactly when the next state is IDLE
    instr_ready_nx = (state_nx == ST_IDLE);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_ready_r <= 1'b1;
      alu_a_r       <= 32'd0;
      alu_b_r       <= 32'd0;
      alu_control_r <= ALU_ADD;
      wb_valid_r    <= 1'b0;
      wb_addr_r     <= 5'd0;
      wb_data_r     <= 32'd0;
      illegal_r     <= 1'b0;
      retired_r     <= '0;
`ifdef ALU_SEQ_OVF_EN
      ovf_kind_r    <= OVF_NONE;
      ovf_r         <= 1'b0;
`endif
    end else begin
      instr_ready_r <= instr_ready_nx;
      alu_a_r       <= alu_a_nx;
      alu_b_r       <= alu_b_nx;
      alu_control_r <= alu_control_nx;
      wb_valid_r    <= wb_valid_nx;
      wb_addr_r     <= wb_addr_nx;
      wb_data_r     <= wb_data_nx;
      illegal_r     <= illegal_nx;
      retired_r     <= retired_nx;
`ifdef ALU_SEQ_OVF_EN
      ovf_kind_r    <= ovf_kind_nx;
      ovf_r         <= ovf_nx;
`endif
    end
  end

  assign instr_ready = instr_ready_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign alu_control = alu_control_r;
  assign wb_valid    = wb_valid_r;
  assign wb_addr     = wb_addr_r;
  assign wb_data     = wb_data_r;
  assign illegal     = illegal_r;
  assign retired     = retired_r;
`ifdef ALU_SEQ_OVF_EN
  assign ovf         = ovf_r;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [31:0] retired;
`ifdef ALU_SEQ_OVF_EN
  logic        ovf;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_retired = 32'd0;

  alu_sequencer #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .retired     (retired)
`ifdef ALU_SEQ_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU
  function automatic logic [31:0] alu_model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a << b[4:0];
      3'b110:  return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_control, alu_a, alu_b);

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Present one instruction for a single rising edge (caller is at a negedge, DUT idle)
  task automatic issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    instr = i;
    rs_data = rs;
    rt_data = rt;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (instr_ready !== 1'b1) $display("FAIL reset_instr_ready got %b want 1", instr_ready); else pass_cnt++;
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", wb_valid); else pass_cnt++;
    total_cnt++; if (alu_control !== 3'b000) $display("FAIL reset_alu_control got %b want 000", alu_control); else pass_cnt++;
    total_cnt++; if (retired !== 32'd0) $display("FAIL reset_retired got %0d want 0", retired); else pass_cnt++;
    total_cnt++; if ({illegal, wb_addr, wb_data, alu_a, alu_b} !== 70'd0)
      $display("FAIL reset_outputs got %b/%h/%h/%h/%h want zeros", illegal, wb_addr, wb_data, alu_a, alu_b); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    wb_ready = 1'b1;
    issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    // cycle N+1: operands registered, still executing
    total_cnt++; if (alu_control !== 3'b000) $display("FAIL add_ctrl got %b want 000", alu_control); else pass_cnt++;
    total_cnt++; if (alu_a !== 32'd5 || alu_b !== 32'd7) $display("FAIL add_operands got %h %h want 5 7", alu_a, alu_b); else pass_cnt++;
    total_cnt++; if (wb_valid !== 1'b0 || instr_ready !== 1'b0)
      $display("FAIL add_n1 got wb_valid=%b ready=%b want 0 0", wb_valid, instr_ready); else pass_cnt++;
    @(negedge clk);
    // cycle N+2: writeback offered
    total_cnt++; if (wb_valid !== 1'b1) $display("FAIL add_wb_valid got %b want 1", wb_valid); else pass_cnt++;
    total_cnt++; if (wb_addr !== 5'd3) $display("FAIL add_wb_addr got %0d want 3", wb_addr); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'd12) $display("FAIL add_wb_data got %0d want 12", wb_data); else pass_cnt++;
    @(negedge clk);
    // cycle N+3: handshake done, ready again
    exp_retired = exp_retired + 32'd1;
    total_cnt++; if (retired !== exp_retired) $display("FAIL add_retired got %0d want %0d", retired, exp_retired); else pass_cnt++;
    total_cnt++; if (wb_valid !== 1'b0 || instr_ready !== 1'b1)
      $display("FAIL add_n3 got wb_valid=%b ready=%b want 0 1", wb_valid, instr_ready); else pass_cnt++;
  endtask

  typedef struct {
    logic [31:0] i;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  task automatic test_decode();
    vec_t v[13];
    v[0]  = '{itype(6'h08, 5'd0, 5'd4, 16'hFFFF), 32'h0, 32'hDEADBEEF, 3'b000, 32'h0, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF};
    v[1]  = '{itype(6'h0D, 5'd0, 5'd5, 16'hFFFF), 32'h0, 32'hDEADBEEF, 3'b011, 32'h0, 32'h0000FFFF, 5'd5, 32'h0000FFFF};
    v[2]  = '{itype(6'h0C, 5'd1, 5'd6, 16'h8F0F), 32'hFFFF1234, 32'hDEADBEEF, 3'b010, 32'hFFFF1234, 32'h00008F0F, 5'd6, 32'h00000204};
    v[3]  = '{itype(6'h0E, 5'd1, 5'd7, 16'h8001), 32'h0000FFFF, 32'hDEADBEEF, 3'b100, 32'h0000FFFF, 32'h00008001, 5'd7, 32'h00007FFE};
    v[4]  = '{rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h22), 32'd3, 32'd5, 3'b001, 32'd3, 32'd5, 5'd8, 32'hFFFFFFFE};
    v[5]  = '{rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h24), 32'hF0F0F0F0, 32'hFF00FF00, 3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd9, 32'hF000F000};
    v[6]  = '{rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h25), 32'h0000000F, 32'h000000F0, 3'b011, 32'h0000000F, 32'h000000F0, 5'd10, 32'h000000FF};
    v[7]  = '{rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h26), 32'hFF00FF00, 32'h0F0F0F0F, 3'b100, 32'hFF00FF00, 32'h0F0F0F0F, 5'd11, 32'hF00FF00F};
    v[8]  = '{rtype(5'd0, 5'd1, 5'd2, 5'd4, 6'h00), 32'h00000063, 32'd1, 3'b101, 32'd1, 32'd4, 5'd2, 32'h00000010};
    v[9]  = '{rtype(5'd3, 5'd1, 5'd12, 5'd0, 6'h04), 32'h00000024, 32'd1, 3'b101, 32'd1, 32'd4, 5'd12, 32'h00000010};
    v[10] = '{rtype(5'd0, 5'd1, 5'd13, 5'd31, 6'h02), 32'h00000005, 32'h80000000, 3'b110, 32'h80000000, 32'd31, 5'd13, 32'd1};
    v[11] = '{rtype(5'd3, 5'd1, 5'd14, 5'd0, 6'h06), 32'hFFFFFFE8, 32'h0000FF00, 3'b110, 32'h0000FF00, 32'd8, 5'd14, 32'h000000FF};
    v[12] = '{itype(6'h08, 5'd1, 5'd15, 16'hFFFE), 32'd10, 32'hDEADBEEF, 3'b000, 32'd10, 32'hFFFFFFFE, 5'd15, 32'd8};
    wb_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      issue(v[k].i, v[k].rs, v[k].rt);
      total_cnt++; if (alu_control !== v[k].ctrl) $display("FAIL dec%0d_ctrl got %b want %b", k, alu_control, v[k].ctrl); else pass_cnt++;
      total_cnt++; if (alu_a !== v[k].a) $display("FAIL dec%0d_alu_a got %h want %h", k, alu_a, v[k].a); else pass_cnt++;
      total_cnt++; if (alu_b !== v[k].b) $display("FAIL dec%0d_alu_b got %h want %h", k, alu_b, v[k].b); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (wb_valid !== 1'b1 || wb_addr !== v[k].addr)
        $display("FAIL dec%0d_wb got valid=%b addr=%0d want 1 %0d", k, wb_valid, wb_addr, v[k].addr); else pass_cnt++;
      total_cnt++; if (wb_data !== v[k].data) $display("FAIL dec%0d_wb_data got %h want %h", k, wb_data, v[k].data); else pass_cnt++;
      @(negedge clk);
      exp_retired = exp_retired + 32'd1;
      total_cnt++; if (retired !== exp_retired) $display("FAIL dec%0d_retired got %0d want %0d", k, retired, exp_retired); else pass_cnt++;
    end
  endtask

  task automatic test_wb_stall();
    wb_ready = 1'b0;
    issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd1, 32'd2);
    @(negedge clk);
    // a second instruction waits while the writeback is stalled
    instr = rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h22);
    rs_data = 32'd10;
    rt_data = 32'd4;
    instr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total_cnt++; if (wb_valid !== 1'b1 || wb_addr !== 5'd3 || wb_data !== 32'd3)
        $display("FAIL stall%0d_hold got valid=%b addr=%0d data=%h want 1 3 3", c, wb_valid, wb_addr, wb_data); else pass_cnt++;
      total_cnt++; if (instr_ready !== 1'b0 || alu_a !== 32'd1)
        $display("FAIL stall%0d_no_accept got ready=%b alu_a=%h want 0 1", c, instr_ready, alu_a); else pass_cnt++;
      @(negedge clk);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    exp_retired = exp_retired + 32'd1;
    total_cnt++; if (wb_valid !== 1'b0 || instr_ready !== 1'b1 || retired !== exp_retired)
      $display("FAIL stall_release got valid=%b ready=%b retired=%0d want 0 1 %0d", wb_valid, instr_ready, retired, exp_retired);
    else pass_cnt++;
    @(negedge clk);
    instr_valid = 1'b0;
    total_cnt++; if (alu_control !== 3'b001 || alu_a !== 32'd10 || alu_b !== 32'd4)
      $display("FAIL stall_next_accept got ctrl=%b a=%h b=%h want 001 a 4", alu_control, alu_a, alu_b); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (wb_valid !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'd6)
      $display("FAIL stall_next_wb got valid=%b addr=%0d data=%h want 1 9 6", wb_valid, wb_addr, wb_data); else pass_cnt++;
    @(negedge clk);
    exp_retired = exp_retired + 32'd1;
    total_cnt++; if (retired !== exp_retired) $display("FAIL stall_next_retired got %0d want %0d", retired, exp_retired); else pass_cnt++;
  endtask

  task automatic test_illegal_r0();
    wb_ready = 1'b1;
    issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h18), 32'd6, 32'd7);
    total_cnt++; if (illegal !== 1'b1 || instr_ready !== 1'b1 || wb_valid !== 1'b0)
      $display("FAIL mult_pulse got illegal=%b ready=%b wb_valid=%b want 1 1 0", illegal, instr_ready, wb_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (illegal !== 1'b0 || wb_valid !== 1'b0 || retired !== exp_retired)
      $display("FAIL mult_after got illegal=%b wb_valid=%b retired=%0d want 0 0 %0d", illegal, wb_valid, retired, exp_retired);
    else pass_cnt++;
    issue(itype(6'h23, 5'd1, 5'd2, 16'h0004), 32'd0, 32'd0);
    total_cnt++; if (illegal !== 1'b1) $display("FAIL lw_pulse got %b want 1", illegal); else pass_cnt++;
    @(negedge clk);
    issue(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 32'd1, 32'd2);
    total_cnt++; if (illegal !== 1'b0 || instr_ready !== 1'b0)
      $display("FAIL r0_exec got illegal=%b ready=%b want 0 0", illegal, instr_ready); else pass_cnt++;
    @(negedge clk);
    exp_retired = exp_retired + 32'd1;
    total_cnt++; if (wb_valid !== 1'b0 || retired !== exp_retired || instr_ready !== 1'b1)
      $display("FAIL r0_retire got wb_valid=%b retired=%0d ready=%b want 0 %0d 1", wb_valid, retired, instr_ready, exp_retired);
    else pass_cnt++;
    issue(32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    exp_retired = exp_retired + 32'd1;
    total_cnt++; if (wb_valid !== 1'b0 || retired !== exp_retired)
      $display("FAIL nop_retire got wb_valid=%b retired=%0d want 0 %0d", wb_valid, retired, exp_retired); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b0;
    issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd1, 32'd2);
    @(negedge clk);
    total_cnt++; if (wb_valid !== 1'b1) $display("FAIL rstmid_pre got wb_valid=%b want 1", wb_valid); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (wb_valid !== 1'b0 || retired !== 32'd0 || instr_ready !== 1'b1)
      $display("FAIL rstmid_async got wb_valid=%b retired=%0d ready=%b want 0 0 1", wb_valid, retired, instr_ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    wb_ready = 1'b1;
    exp_retired = 32'd0;
    @(negedge clk);
    total_cnt++; if (wb_valid !== 1'b0 || retired !== 32'd0)
      $display("FAIL rstmid_dropped got wb_valid=%b retired=%0d want 0 0", wb_valid, retired); else pass_cnt++;
    issue(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 32'd1, 32'd2);
    @(negedge clk);
    exp_retired = 32'd1;
    total_cnt++; if (retired !== exp_retired) $display("FAIL rstmid_resume got %0d want 1", retired); else pass_cnt++;
  endtask

  task automatic test_overflow();
    wb_ready = 1'b1;
`ifdef ALU_SEQ_OVF_EN
    issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFFFFFF, 32'd1);
    total_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_add_early got %b want 0", ovf); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ovf !== 1'b1 || wb_valid !== 1'b0 || instr_ready !== 1'b1)
      $display("FAIL ovf_add got ovf=%b wb_valid=%b ready=%b want 1 0 1", ovf, wb_valid, instr_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ovf !== 1'b0 || retired !== exp_retired)
      $display("FAIL ovf_add_after got ovf=%b retired=%0d want 0 %0d", ovf, retired, exp_retired); else pass_cnt++;
    issue(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h22), 32'h80000000, 32'd1);
    @(negedge clk);
    total_cnt++; if (ovf !== 1'b1 || wb_valid !== 1'b0)
      $display("FAIL ovf_sub got ovf=%b wb_valid=%b want 1 0", ovf, wb_valid); else pass_cnt++;
    @(negedge clk);
    issue(rtype(5'd1, 5'd2, 5'd5, 5'd0, 6'h20), 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    total_cnt++; if (ovf !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'd0)
      $display("FAIL ovf_none got ovf=%b wb_valid=%b data=%h want 0 1 0", ovf, wb_valid, wb_data); else pass_cnt++;
    @(negedge clk);
    exp_retired = exp_retired + 32'd1;
    total_cnt++; if (retired !== exp_retired) $display("FAIL ovf_none_retired got %0d want %0d", retired, exp_retired); else pass_cnt++;
`else
    issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFFFFFF, 32'd1);
    @(negedge clk);
    total_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'h80000000)
      $display("FAIL wrap_add got wb_valid=%b data=%h want 1 80000000", wb_valid, wb_data); else pass_cnt++;
    @(negedge clk);
    exp_retired = exp_retired + 32'd1;
    total_cnt++; if (retired !== exp_retired) $display("FAIL wrap_retired got %0d want %0d", retired, exp_retired); else pass_cnt++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 32'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    wb_ready = 1'b0;
    test_reset();
    test_add();
    test_decode();
    test_wb_stall();
    test_illegal_r0();
    test_reset_mid();
    test_overflow();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
